// File: rtl/dphy_pkg.sv
// Shared definitions for the dibit serializer/deserializer pair.
// Holds the dibit count per byte and the assembler state encoding.
package dphy_pkg;

    localparam int DIBITS_PER_BYTE = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } asm_state_t;

endpackage

// File: rtl/dphy_byte_fifo.sv
// Single-clock show-ahead byte FIFO with an explicit occupancy counter.
// Ports: clk, reset_n, push, pop, din -> dout, level, full, empty.
module dphy_byte_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty
);

    logic [7:0]        mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [7:0]        last;
    logic              do_pop;
    logic              do_push;

    assign empty   = (count == '0);
    assign full    = (count == (ADDR_W+1)'(FIFO_DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign level   = count;

    // While empty, keep presenting the most recently popped byte.
    assign dout = empty ? last : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last   <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                last   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/dphy_2to8.sv
// Dibit-to-byte deserializer: reassembles LSB-first dibits into bytes and
// buffers them in a show-ahead FIFO. Ports: clk, reset_n, d_valid, d_in,
// q_ready -> q_valid, q, level, overflow (sticky), frag_err (pulse).
module dphy_2to8
    import dphy_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            d_valid,
    input  logic [1:0]      d_in,
    input  logic            q_ready,
    output logic            q_valid,
    output logic [7:0]      q,
    output logic [ADDR_W:0] level,
    output logic            overflow,
    output logic            frag_err
);

    localparam logic [1:0] LAST_IDX = 2'(DIBITS_PER_BYTE - 1);

    asm_state_t state, state_n;
    logic [1:0] idx, idx_n;
    logic [5:0] shift, shift_n;
    logic       frag_n;
    logic       byte_done;
    logic [7:0] byte_data;
    logic       full;
    logic       empty;
    logic       pop;
    logic       push;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            idx      <= '0;
            shift    <= '0;
            frag_err <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            shift    <= shift_n;
            frag_err <= frag_n;
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        shift_n   = shift;
        frag_n    = 1'b0;
        byte_done = 1'b0;
        unique case (state)
            IDLE: begin
                // Any valid after a gap restarts alignment at dibit 0.
                if (d_valid) begin
                    shift_n[1:0] = d_in;
                    idx_n        = 2'd1;
                    state_n      = COLLECT;
                end
            end
            COLLECT: begin
                if (d_valid) begin
                    if (idx == LAST_IDX) begin
                        byte_done = 1'b1;
                    end else begin
                        shift_n[2*idx +: 2] = d_in;
                    end
                    idx_n = idx + 2'd1;
                end else begin
                    frag_n  = (idx != 2'd0);
                    idx_n   = '0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign byte_data = {d_in, shift};
    assign pop       = q_valid & q_ready;
    assign push      = byte_done & (~full | pop);
    assign q_valid   = ~empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (byte_done && full && !pop) begin
            overflow <= 1'b1;
        end
    end

    dphy_byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (byte_data),
        .dout    (q),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

endmodule
